// File: rtl/pacman_pkg.sv
// Shared types and widths for the dot-eating scoreboard.
package pacman_pkg;

  localparam int NUM_DOTS = 32;
  localparam int CNT_W    = 6;   // holds 0..NUM_DOTS
  localparam int SCORE_W  = 16;
  localparam int LEVEL_W  = 4;
  localparam int SUM_W    = 18;  // headroom so score addition never wraps before saturation

  localparam logic [LEVEL_W-1:0] MAX_LEVEL = 4'd15;

  typedef enum logic [1:0] {
    PLAY,
    HOLD,
    RESTART
  } state_e;

endpackage

// File: rtl/popcount32.sv
// Combinational population count of a 32-bit dot vector.
module popcount32
  import pacman_pkg::*;
(
  input  logic [NUM_DOTS-1:0] bits_i,
  output logic [CNT_W-1:0]    count_o
);

  // NOTE: combinational logic uses blocking '=' so the running sum updates in
  // loop order; clocked state elsewhere uses non-blocking '<='.
  always_comb begin
    count_o = '0;
    for (int i = 0; i < NUM_DOTS; i++) begin
      count_o = count_o + CNT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/dot_scorer.sv
// Counts newly eaten dots, accumulates a saturating score, and sequences
// level clear -> hold -> restart of the dot array.
module dot_scorer
  import pacman_pkg::*;
#(
  parameter int POINTS_PER_DOT = 10,
  parameter int MAX_SCORE      = 9999,
  parameter int CLEAR_HOLD     = 120
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [NUM_DOTS-1:0] eaten_mask,
  input  logic                frame_tick,
  output logic [SCORE_W-1:0]  score,
  output logic [CNT_W-1:0]    dots_eaten,
  output logic [LEVEL_W-1:0]  level,
  output logic                eat_pulse,
  output logic                level_clear,
  output logic                level_reset
);

  localparam int FC_W = (CLEAR_HOLD < 2) ? 1 : $clog2(CLEAR_HOLD);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(CLEAR_HOLD - 1);

  state_e              state_q, state_d;
  logic [NUM_DOTS-1:0] prev_mask_q, prev_mask_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [CNT_W-1:0]    dots_q, dots_d;
  logic [LEVEL_W-1:0]  level_q, level_d;
  logic [FC_W-1:0]     frame_q, frame_d;
  logic                eat_pulse_q, eat_pulse_d;
  logic                clear_q, clear_d;
  logic                restart_q, restart_d;

  logic [NUM_DOTS-1:0] new_eats;
  logic [CNT_W-1:0]    n_new;
  logic [CNT_W:0]      dots_sum;
  logic [SUM_W-1:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;

  // Only rising bits are eats; a dot reappearing (1->0) is ignored.
  assign new_eats = eaten_mask & ~prev_mask_q;

  popcount32 u_popcount (
    .bits_i  (new_eats),
    .count_o (n_new)
  );

  assign dots_sum  = {1'b0, dots_q} + {1'b0, n_new};
  assign score_sum = SUM_W'(score_q) + SUM_W'(n_new) * SUM_W'(POINTS_PER_DOT);
  assign score_sat = (score_sum > SUM_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE)
                                                     : score_sum[SCORE_W-1:0];

  // NOTE: every next-state signal gets its hold value first so no path through
  // the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    prev_mask_d = prev_mask_q;
    score_d     = score_q;
    dots_d      = dots_q;
    level_d     = level_q;
    frame_d     = frame_q;
    eat_pulse_d = 1'b0;

    case (state_q)
      PLAY: begin
        prev_mask_d = eaten_mask;
        if (n_new != '0) begin
          dots_d      = (dots_sum >= (CNT_W+1)'(NUM_DOTS)) ? CNT_W'(NUM_DOTS)
                                                           : dots_sum[CNT_W-1:0];
          score_d     = score_sat;
          eat_pulse_d = 1'b1;
          if (dots_sum >= (CNT_W+1)'(NUM_DOTS)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (frame_tick) begin
          if (frame_q == FC_LAST) state_d = RESTART;
          else                    frame_d = frame_q + 1'b1;
        end
      end
      RESTART: begin
        state_d     = PLAY;
        dots_d      = '0;
        prev_mask_d = '0;
        frame_d     = '0;
        if (level_q != MAX_LEVEL) level_d = level_q + 1'b1;
      end
      default: state_d = PLAY;
    endcase
  end

  // Status flags track the state being entered so they are registered too.
  assign clear_d   = (state_d == HOLD);
  assign restart_d = (state_d == RESTART);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= PLAY;
      prev_mask_q <= '0;
      score_q     <= '0;
      dots_q      <= '0;
      level_q     <= LEVEL_W'(1);
      frame_q     <= '0;
      eat_pulse_q <= 1'b0;
      clear_q     <= 1'b0;
      restart_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_mask_q <= prev_mask_d;
      score_q     <= score_d;
      dots_q      <= dots_d;
      level_q     <= level_d;
      frame_q     <= frame_d;
      eat_pulse_q <= eat_pulse_d;
      clear_q     <= clear_d;
      restart_q   <= restart_d;
    end
  end

  assign score       = score_q;
  assign dots_eaten  = dots_q;
  assign level       = level_q;
  assign eat_pulse   = eat_pulse_q;
  assign level_clear = clear_q;
  assign level_reset = restart_q;

endmodule

// File: doc/dot_scorer.md
DOT_SCORER -- requirements
Module: dot_scorer

Interface
REQ-001 SHALL have parameter POINTS_PER_DOT, default 10, score added per newly eaten dot.
REQ-002 SHALL have parameter MAX_SCORE, default 9999, saturation ceiling of score.
REQ-003 SHALL have parameter CLEAR_HOLD, default 120, frame_tick pulses spent in HOLD after level clear.
REQ-004 SHALL have port Clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port eaten_mask  input  32  per-dot eaten flags from the dot array (1 = eaten).
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 SHALL have port score  output  16  accumulated binary score.
REQ-009 SHALL have port dots_eaten  output  6  dots eaten this level, 0..32.
REQ-010 SHALL have port level  output  4  current level, 1..15.
REQ-011 SHALL have port eat_pulse  output  1  one-cycle pulse when at least one new eat is counted.
REQ-012 SHALL have port level_clear  output  1  high while in HOLD.
REQ-013 SHALL have port level_reset  output  1  one-cycle pulse that resets the dot array for the next level.

Function
REQ-014 SHALL keep register prev_mask; new_eats = eaten_mask & ~prev_mask; n = popcount(new_eats), 0..32.
REQ-015 SHALL use FSM states PLAY, HOLD, RESTART.
REQ-016 In PLAY, on each edge: prev_mask <= eaten_mask; if n>0, dots_eaten += n, score += n*POINTS_PER_DOT, eat_pulse asserted next cycle; outputs change one cycle after the mask change.
REQ-017 Score addition SHALL be computed at 17+ bits and saturate at MAX_SCORE; never wrap.
REQ-018 Multiple dots newly eaten in the same cycle SHALL all be counted (full popcount, no loss).
REQ-019 Bits falling 1->0 in eaten_mask SHALL not change score or dots_eaten.
REQ-020 PLAY->HOLD on the edge where dots_eaten+n reaches 32; the counted eats on that edge are still scored.
REQ-021 In HOLD, eaten_mask changes SHALL be ignored (no score, no eat_pulse); a frame counter increments per frame_tick.
REQ-022 HOLD->RESTART on the edge where the CLEAR_HOLD-th frame_tick is seen; level_reset = 1 exactly during the single RESTART cycle.
REQ-023 RESTART->PLAY unconditionally next edge; on that edge dots_eaten <= 0, prev_mask <= 0, frame counter <= 0, level <= level+1 saturating at 15; score retained.
REQ-024 frame_tick coincident with the PLAY->HOLD edge SHALL not count toward CLEAR_HOLD.
REQ-025 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-026 On Reset: state PLAY, score 0, dots_eaten 0, level 1, prev_mask 0, frame counter 0, eat_pulse 0, level_clear 0, level_reset 0.
REQ-027 Reset SHALL override every other event, including mid-HOLD and the RESTART cycle; no level_reset pulse is produced by Reset.
REQ-028 If eaten_mask is nonzero on the first PLAY cycle after Reset, those bits SHALL be counted as new eats.

Structure
REQ-029 Shared package pacman_pkg SHALL hold the state enum (PLAY, HOLD, RESTART), NUM_DOTS = 32, and score/level widths.
REQ-030 A sub-module popcount32 (32-bit in, 6-bit count out, combinational) SHALL compute n.

Verification
REQ-031 Reset, then eaten_mask 0 -> 0x00000001 -> score 10, dots_eaten 1, eat_pulse one cycle, one cycle after the change.
REQ-032 eaten_mask 0 -> 0x0000000F in one cycle -> score 40, dots_eaten 4, single eat_pulse.
REQ-033 eaten_mask to 0xFFFFFFFF -> dots_eaten 32, level_clear 1; after 120 frame_ticks exactly one level_reset pulse, then level 2, dots_eaten 0, score 320 retained.
REQ-034 During HOLD, toggle eaten_mask bits -> score unchanged, no eat_pulse.
REQ-035 Preload via repeated levels/clears until score near 9999, then eat 4 dots -> score 9999 exactly, no wrap.
REQ-036 Assert Reset at HOLD frame 50 -> all outputs return to reset values next cycle, no level_reset pulse.
